vmsu_wb_bridge: RTL and testbench

Wishbone slave front-end for the 8-bit multiplier. It sits directly upstream of `vmsu_8bit_top` and replaces the logic-analyser drive of that block. The management SoC writes operand pairs over Wishbone; the bridge launches each multiply, waits a fixed latency, captures the 16-bit product into a small result FIFO, and raises an optional interrupt when results are pending.

---
 rtl/vmsu_wb_bridge.sv | 198 +++++++++++++++++++
 tb/tb_vmsu_wb_bridge.sv | 282 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/vmsu_wb_bridge.sv
// vmsu_wb_bridge: Wishbone slave front-end for the 8-bit multiplier.
// Accepts operand writes, launches a multiply, waits MUL_LATENCY cycles,
// captures the product into a small result FIFO and reports status.
// Optional interrupt output is built when VMSU_BRIDGE_IRQ_EN is defined.
module vmsu_wb_bridge #(
  parameter logic [31:0] ADDR_BASE   = 32'h3000_0000,
  parameter int unsigned MUL_LATENCY = 2,
  parameter int unsigned FIFO_DEPTH  = 4
) (
  input  logic        wb_clk_i,
  input  logic        wb_rst_i,
  input  logic        wbs_stb_i,
  input  logic        wbs_cyc_i,
  input  logic        wbs_we_i,
  input  logic [3:0]  wbs_sel_i,
  input  logic [31:0] wbs_adr_i,
  input  logic [31:0] wbs_dat_i,
  output logic        wbs_ack_o,
  output logic [31:0] wbs_dat_o,
  output logic [7:0]  mul_a,
  output logic [7:0]  mul_b,
  output logic        mul_control,
  input  logic [15:0] mul_p,
  output logic        irq
);

  localparam int unsigned AW = $clog2(FIFO_DEPTH);
  localparam int unsigned CW = AW + 1;

  typedef enum logic {S_IDLE, S_WAIT} state_t;

  state_t          state_q, state_d;
  logic [3:0]      cnt_q, cnt_d;
  logic            ack_q, ack_d;
  logic [31:0]     dat_q, dat_d;
  logic [7:0]      a_q, a_d, b_q, b_d;
  logic            ctl_q, ctl_d;
  logic            ovf_q, ovf_d;
  logic            lerr_q, lerr_d;
  logic [AW-1:0]   wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic [CW-1:0]   count_q, count_d;
  logic [15:0]     mem_q [FIFO_DEPTH];
  logic [15:0]     mem_d [FIFO_DEPTH];
  logic            irq_en_q;

  logic            addr_hit, req, wr_req, rd_req;
  logic [1:0]      off;
  logic            empty, full, busy, capture, pop, push;
  logic [4:0]      count_ext;
  logic            unused_ok;

  assign unused_ok = ^{wbs_sel_i, wbs_adr_i[1:0], wbs_dat_i[31:17]};

  assign addr_hit  = (wbs_adr_i[31:4] == ADDR_BASE[31:4]);
  // ack_q blocks re-acceptance so ack can never be asserted back to back
  assign req       = wbs_cyc_i & wbs_stb_i & addr_hit & ~ack_q;
  assign wr_req    = req & wbs_we_i;
  assign rd_req    = req & ~wbs_we_i;
  assign off       = wbs_adr_i[3:2];

  assign empty     = (count_q == '0);
  assign full      = (count_q == CW'(FIFO_DEPTH));
  assign busy      = (state_q == S_WAIT);
  assign capture   = busy && (cnt_q == 4'd0);
  assign pop       = rd_req && (off == 2'd2) && !empty;
  // a pop on the capture edge frees a slot, so a full FIFO still accepts
  assign push      = capture && (!full || pop);
  assign count_ext = 5'(count_q);

  assign wbs_ack_o   = ack_q;
  assign wbs_dat_o   = dat_q;
  assign mul_a       = a_q;
  assign mul_b       = b_q;
  assign mul_control = ctl_q;

`ifdef VMSU_BRIDGE_IRQ_EN
  logic irq_en_d, irq_q, irq_d;

  // interrupt enable register and registered interrupt
  always_comb begin
    irq_en_d = irq_en_q;
    if (wr_req && off == 2'd3) irq_en_d = wbs_dat_i[0];
    irq_d = irq_en_q & ~empty;
  end

  // interrupt state flops
  always_ff @(posedge wb_clk_i or posedge wb_rst_i) begin
    if (wb_rst_i) begin
      irq_en_q <= 1'b0;
      irq_q    <= 1'b0;
    end else begin
      irq_en_q <= irq_en_d;
      irq_q    <= irq_d;
    end
  end

  assign irq = irq_q;
`else
  assign irq_en_q = 1'b0;
  assign irq      = 1'b0;
`endif

  // bus decode, launch FSM, sticky flags and FIFO bookkeeping
  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    a_d      = a_q;
    b_d      = b_q;
    ctl_d    = ctl_q;
    ovf_d    = ovf_q;
    lerr_d   = lerr_q;
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    mem_d    = mem_q;
    ack_d    = req;
    dat_d    = '0;

    if (rd_req) begin
      case (off)
        2'd1:    dat_d = {19'd0, count_ext, 3'd0, lerr_q, ovf_q, full, empty, busy};
        2'd2:    if (!empty) dat_d = {1'b1, 15'd0, mem_q[rd_ptr_q]};
        2'd3:    dat_d = {31'd0, irq_en_q};
        default: dat_d = '0;
      endcase
    end

    // clears are applied before sets so a same-edge event is not lost
    if (wr_req && off == 2'd3) begin
      if (wbs_dat_i[1]) ovf_d  = 1'b0;
      if (wbs_dat_i[2]) lerr_d = 1'b0;
    end

    case (state_q)
      S_IDLE: begin
        if (wr_req && off == 2'd0) begin
          state_d = S_WAIT;
          cnt_d   = 4'(MUL_LATENCY - 1);
          a_d     = wbs_dat_i[7:0];
          b_d     = wbs_dat_i[15:8];
          ctl_d   = wbs_dat_i[16];
        end
      end
      S_WAIT: begin
        if (cnt_q == 4'd0) state_d = S_IDLE;
        else               cnt_d   = cnt_q - 4'd1;
        if (wr_req && off == 2'd0) lerr_d = 1'b1;
      end
      default: state_d = S_IDLE;
    endcase

    if (capture && !push) ovf_d = 1'b1;

    if (pop) rd_ptr_d = rd_ptr_q + AW'(1);
    if (push) begin
      mem_d[wr_ptr_q] = mul_p;
      wr_ptr_d        = wr_ptr_q + AW'(1);
    end
    count_d = count_q + CW'(push) - CW'(pop);
  end

  // control and datapath registers
  always_ff @(posedge wb_clk_i or posedge wb_rst_i) begin
    if (wb_rst_i) begin
      state_q  <= S_IDLE;
      cnt_q    <= '0;
      ack_q    <= 1'b0;
      dat_q    <= '0;
      a_q      <= '0;
      b_q      <= '0;
      ctl_q    <= 1'b0;
      ovf_q    <= 1'b0;
      lerr_q   <= 1'b0;
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      ack_q    <= ack_d;
      dat_q    <= dat_d;
      a_q      <= a_d;
      b_q      <= b_d;
      ctl_q    <= ctl_d;
      ovf_q    <= ovf_d;
      lerr_q   <= lerr_d;
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  // result storage; contents are only visible through count-qualified reads
  always_ff @(posedge wb_clk_i) begin
    mem_q <= mem_d;
  end

endmodule

// File: tb/tb_vmsu_wb_bridge.sv
// Self-checking bench for vmsu_wb_bridge: queue-based reference model,
// per-cycle output comparison, directed scenarios and random traffic.
// Honours VMSU_BRIDGE_IRQ_EN when the build defines it.
module tb_vmsu_wb_bridge;

  localparam logic [31:0] BASE  = 32'h3000_0000;
  localparam int unsigned LAT   = 4;
  localparam int unsigned DEPTH = 4;
`ifdef VMSU_BRIDGE_IRQ_EN
  localparam bit IRQ_ON = 1'b1;
`else
  localparam bit IRQ_ON = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        stb = 1'b0, cyc = 1'b0, we = 1'b0;
  logic [3:0]  sel = 4'hF;
  logic [31:0] adr = '0, dat_i = '0;
  logic        ack;
  logic [31:0] dat_o;
  logic [7:0]  ma, mb;
  logic        mc;
  logic [15:0] mp;
  logic        irq;

  int errors = 0;
  int checks = 0;

  vmsu_wb_bridge #(
    .ADDR_BASE  (BASE),
    .MUL_LATENCY(LAT),
    .FIFO_DEPTH (DEPTH)
  ) dut (
    .wb_clk_i   (clk),
    .wb_rst_i   (rst),
    .wbs_stb_i  (stb),
    .wbs_cyc_i  (cyc),
    .wbs_we_i   (we),
    .wbs_sel_i  (sel),
    .wbs_adr_i  (adr),
    .wbs_dat_i  (dat_i),
    .wbs_ack_o  (ack),
    .wbs_dat_o  (dat_o),
    .mul_a      (ma),
    .mul_b      (mb),
    .mul_control(mc),
    .mul_p      (mp),
    .irq        (irq)
  );

  // multiplier stand-in: combinational unsigned product
  assign mp = 16'(ma) * 16'(mb);

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // ---------------- reference model ----------------
  int unsigned  cyc_n;
  bit           m_busy;
  int unsigned  m_cap;
  int unsigned  q[$];
  bit           m_ovf, m_lerr, m_irqen, m_irq, m_ack, m_c;
  logic [31:0]  m_dat;
  logic [7:0]   m_a, m_b;
  bit           hit, capture, mpop, busy0, irqen0;
  int unsigned  sz;
  logic [1:0]   moff;
  logic [31:0]  rdv;

  always @(posedge clk) begin
    if (rst) begin
      cyc_n = 0; m_busy = 0; m_cap = 0; q.delete();
      m_ovf = 0; m_lerr = 0; m_irqen = 0; m_irq = 0; m_ack = 0; m_c = 0;
      m_dat = '0; m_a = '0; m_b = '0;
    end else begin
      sz      = q.size();
      busy0   = m_busy;
      irqen0  = m_irqen;
      moff    = adr[3:2];
      hit     = cyc && stb && (adr[31:4] == BASE[31:4]) && !m_ack;
      capture = m_busy && (cyc_n == m_cap);
      mpop    = hit && !we && moff == 2'd2 && sz > 0;
      rdv     = '0;
      if (hit && !we) begin
        case (moff)
          2'd1: begin
            rdv[12:8] = 5'(sz);
            rdv[4] = m_lerr; rdv[3] = m_ovf; rdv[2] = (sz == DEPTH);
            rdv[1] = (sz == 0); rdv[0] = m_busy;
          end
          2'd2: if (mpop) rdv = 32'h8000_0000 | (q[0] & 32'hFFFF);
          2'd3: rdv[0] = m_irqen;
          default: rdv = '0;
        endcase
      end
      if (mpop) void'(q.pop_front());
      if (hit && we && moff == 2'd3) begin
        if (IRQ_ON) m_irqen = dat_i[0];
        if (dat_i[1]) m_ovf = 0;
        if (dat_i[2]) m_lerr = 0;
      end
      if (capture) begin
        if (sz < DEPTH || mpop) q.push_back(32'(m_a) * 32'(m_b));
        else m_ovf = 1;
        m_busy = 0;
      end
      if (hit && we && moff == 2'd0) begin
        if (busy0) m_lerr = 1;
        else begin
          m_a = dat_i[7:0]; m_b = dat_i[15:8]; m_c = dat_i[16];
          m_busy = 1; m_cap = cyc_n + LAT;
        end
      end
      m_irq = IRQ_ON && irqen0 && (sz > 0);
      m_ack = hit;
      m_dat = rdv;
      cyc_n++;
    end
  end

  // per-cycle comparison of every output against the model
  always @(posedge clk) begin
    #1;
    if (!rst) begin
      check("ack",  64'(ack),   64'(m_ack));
      check("dat",  64'(dat_o), 64'(m_dat));
      check("mul_a", 64'(ma),   64'(m_a));
      check("mul_b", 64'(mb),   64'(m_b));
      check("mul_c", 64'(mc),   64'(m_c));
      check("irq",  64'(irq),   64'(m_irq));
    end
  end

  // ---------------- bus tasks (called at a negedge) ----------------
  task automatic bus(input bit w, input logic [1:0] off, input logic [31:0] d,
                     output logic [31:0] r);
    bit got = 0;
    cyc = 1; stb = 1; we = w; adr = BASE | {28'd0, off, 2'b00}; dat_i = d; r = '0;
    for (int i = 0; i < 6; i++) begin
      @(posedge clk); #1;
      if (ack) begin r = dat_o; got = 1; break; end
    end
    checks++;
    if (!got) begin
      errors++;
      $display("FAIL ack_timeout: got no ack expected ack within 6 cycles at %0t", $time);
    end
    @(negedge clk);
    cyc = 0; stb = 0; we = 0;
  endtask

  task automatic wr(input logic [1:0] off, input logic [31:0] d);
    logic [31:0] r;
    bus(1'b1, off, d, r);
  endtask

  task automatic rd(input logic [1:0] off, output logic [31:0] r);
    bus(1'b0, off, '0, r);
  endtask

  task automatic nomatch(input bit w);
    cyc = 1; stb = 1; we = w; dat_i = $urandom;
    adr = (BASE ^ (32'h10 << $urandom_range(0, 27))) | {28'd0, 2'($urandom), 2'b00};
    for (int i = 0; i < 3; i++) begin
      @(posedge clk); #1;
      check("nomatch_ack", 64'(ack), 64'd0);
    end
    @(negedge clk);
    cyc = 0; stb = 0; we = 0;
  endtask

  task automatic launch_wait(input logic [7:0] a, input logic [7:0] b);
    wr(2'd0, {16'd0, b, a});
    repeat (LAT + 1) @(negedge clk);
  endtask

  // ---------------- stimulus ----------------
  initial begin
    logic [31:0] r;
    repeat (2) @(negedge clk);
    rst = 0;
    @(negedge clk);

    // single multiply
    wr(2'd0, 32'h0000_0C05);
    check("single_mul_a", 64'(ma), 64'd5);
    check("single_mul_b", 64'(mb), 64'd12);
    repeat (LAT + 1) @(negedge clk);
    rd(2'd2, r);  check("single_result", 64'(r), 64'h8000_003C);
    rd(2'd1, r);  check("single_status_empty", 64'(r), 64'h2);

    // reset mid-operation, asserted asynchronously mid-cycle
    wr(2'd0, 32'h0001_0302);
    @(posedge clk); #2;
    rst = 1; #1;
    check("rst_ack",  64'(ack),   64'd0);
    check("rst_dat",  64'(dat_o), 64'd0);
    check("rst_mul",  64'({ma, mb, mc}), 64'd0);
    check("rst_irq",  64'(irq),   64'd0);
    repeat (2) @(negedge clk);
    rst = 0;
    repeat (LAT + 2) @(negedge clk);
    rd(2'd1, r);  check("rst_status", 64'(r), 64'h2);
    rd(2'd3, r);  check("rst_ctrl", 64'(r), 64'd0);

    // busy collision
    wr(2'd0, 32'h0000_0201);
    wr(2'd0, 32'h0000_0403);
    check("collide_mul_a", 64'(ma), 64'd1);
    repeat (LAT + 1) @(negedge clk);
    rd(2'd1, r);  check("collide_status", 64'(r), 64'h110);
    wr(2'd3, 32'h4);
    rd(2'd1, r);  check("collide_cleared", 64'(r), 64'h100);
    rd(2'd2, r);  check("collide_result", 64'(r), 64'h8000_0002);

    // FIFO full and overflow
    for (int i = 0; i <= DEPTH; i++) launch_wait(8'(i + 3), 8'(i + 7));
    rd(2'd1, r);  check("ovf_status", 64'(r), 64'((DEPTH << 8) | 32'hC));
    for (int i = 0; i < DEPTH; i++) begin
      rd(2'd2, r);
      check("ovf_result", 64'(r), 64'(32'h8000_0000 | ((i + 3) * (i + 7))));
    end
    rd(2'd2, r);  check("empty_result", 64'(r), 64'd0);
    wr(2'd3, 32'h2);
    rd(2'd1, r);  check("ovf_cleared", 64'(r), 64'h2);

    // simultaneous push and pop on a full FIFO
    for (int i = 0; i < DEPTH; i++) launch_wait(8'(10 + i), 8'd2);
    wr(2'd0, 32'h0000_0307);
    repeat (LAT - 1) @(negedge clk);
    rd(2'd2, r);  check("pushpop_result", 64'(r), 64'h8000_0014);
    rd(2'd1, r);  check("pushpop_status", 64'(r), 64'((DEPTH << 8) | 32'h4));
    for (int i = 1; i < DEPTH; i++) begin
      rd(2'd2, r);
      check("pushpop_drain", 64'(r), 64'(32'h8000_0000 | ((10 + i) * 2)));
    end
    rd(2'd2, r);  check("pushpop_last", 64'(r), 64'h8000_0015);

    // interrupt
    wr(2'd3, 32'h1);
    rd(2'd3, r);  check("ctrl_irq_en", 64'(r), 64'(IRQ_ON));
    launch_wait(8'd6, 8'd7);
    check("irq_rise", 64'(irq), 64'(IRQ_ON));
    rd(2'd2, r);  check("irq_result", 64'(r), 64'h8000_002A);
    @(posedge clk); #1;
    check("irq_fall", 64'(irq), 64'd0);
    @(negedge clk);

    // random traffic
    for (int n = 0; n < 400; n++) begin
      case ($urandom_range(0, 9))
        0, 1, 2, 3: wr(2'd0, {15'd0, 17'($urandom)});
        4, 5:       rd(2'd2, r);
        6:          rd(2'd1, r);
        7:          wr(2'd3, 32'($urandom_range(0, 7)));
        8:          if ($urandom_range(0, 1) == 0) rd(2'($urandom_range(0, 3)), r);
                    else wr(2'd1, $urandom);
        default:    nomatch(1'($urandom));
      endcase
      repeat ($urandom_range(0, 3)) @(negedge clk);
    end
    repeat (LAT + 2) @(negedge clk);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: got no finish expected finish before 500000");
    $fatal(1);
  end

endmodule
